sd_card_cmd_responder: RTL and testbench

Card-side end of the SD CMD line. It receives the 48-bit command frames the host CMD block serializes onto CMD_PIN_OUT, checks framing and CRC7, and presents index and argument to card logic. After NCR idle cycles it serializes a 48-bit response (R1/R3/R7 format) back onto the shared CMD line. It serves as the bus-functional card for host verification and as the front end of a future card model.

---
 rtl/sd_card_cmd_responder.sv | 193 +++++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host command frames, checks framing and CRC7,
// presents index/argument to card logic and, after NCR idle cycles, returns a 48-bit response.
module sd_card_cmd_responder #(
   parameter int unsigned NCR           = 2,
   parameter logic [5:0]  NO_RESP_INDEX = 6'd0
) (
   input  logic        clk_SD,
   input  logic        reset_SD,
   input  logic        CMD_PIN_IN,
   output logic        CMD_PIN_OUT,
   output logic        io_enable_cmd,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_argument,
   output logic        cmd_valid,
   output logic        crc_error,
   input  logic [31:0] card_status,
   input  logic [5:0]  resp_index,
   input  logic        resp_crc_en,
   output logic        busy
);

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StCheck,
      StWaitNcr,
      StSend
   } state_e;

   localparam logic [6:0] NcrLast   = 7'(NCR - 1);
   localparam logic [6:0] FrameLast = 7'd47;
   localparam logic [6:0] FrameBits = 7'd48;
   localparam logic [6:0] CrcBits   = 7'd40;

   // One serial step of CRC7, generator x^7 + x^3 + 1.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // CRC7 over a 40-bit header, MSB first.
   function automatic logic [6:0] crc7_hdr(input logic [39:0] hdr);
      logic [6:0] crc;
      crc = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         crc = crc7_step(crc, hdr[i]);
      end
      return crc;
   endfunction

   state_e      r_state, w_state_nxt;
   logic [6:0]  r_cnt, w_cnt_nxt;
   logic [47:0] r_shift, w_shift_nxt;
   logic [6:0]  r_crc, w_crc_nxt;
   logic [47:0] r_resp, w_resp_nxt;
   logic        r_out, w_out_nxt;
   logic        r_oe, w_oe_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_err, w_err_nxt;
   logic [5:0]  r_index, w_index_nxt;
   logic [31:0] r_arg, w_arg_nxt;

   logic        w_frame_ok;
   logic [39:0] w_resp_hdr;
   logic [6:0]  w_resp_crc;

   // Frame and response-header decode used by the CHECK state.
   always_comb begin
      w_frame_ok = !r_shift[47] && r_shift[46] && r_shift[0] && (r_shift[7:1] == r_crc);
      w_resp_hdr = {2'b00, resp_index, card_status};
      w_resp_crc = resp_crc_en ? crc7_hdr(w_resp_hdr) : 7'h7F;
   end

   // Next-state and datapath for the receive/check/wait/send sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_crc_nxt   = r_crc;
      w_resp_nxt  = r_resp;
      w_out_nxt   = r_out;
      w_oe_nxt    = r_oe;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_index_nxt = r_index;
      w_arg_nxt   = r_arg;

      unique case (r_state)
         StIdle: begin
            if (!CMD_PIN_IN) begin
               w_shift_nxt = {r_shift[46:0], 1'b0};
               w_crc_nxt   = crc7_step(7'h00, 1'b0);
               w_cnt_nxt   = 7'd1;
               w_state_nxt = StRecv;
            end
         end

         StRecv: begin
            w_shift_nxt = {r_shift[46:0], CMD_PIN_IN};
            w_cnt_nxt   = r_cnt + 7'd1;
            // r_cnt is the number of bits already captured; CRC covers frame bits 47..8.
            if (r_cnt < CrcBits) begin
               w_crc_nxt = crc7_step(r_crc, CMD_PIN_IN);
            end
            if (r_cnt == FrameLast) begin
               w_state_nxt = StCheck;
            end
         end

         StCheck: begin
            if (w_frame_ok) begin
               w_valid_nxt = 1'b1;
               w_index_nxt = r_shift[45:40];
               w_arg_nxt   = r_shift[39:8];
               w_resp_nxt  = {w_resp_hdr, w_resp_crc, 1'b1};
               w_cnt_nxt   = 7'd0;
               w_state_nxt = (r_shift[45:40] == NO_RESP_INDEX) ? StIdle : StWaitNcr;
            end else begin
               w_err_nxt   = 1'b1;
               w_state_nxt = StIdle;
            end
         end

         StWaitNcr: begin
            if (r_cnt == NcrLast) begin
               w_out_nxt   = r_resp[47];
               w_resp_nxt  = {r_resp[46:0], 1'b1};
               w_oe_nxt    = 1'b1;
               w_cnt_nxt   = 7'd1;
               w_state_nxt = StSend;
            end else begin
               w_cnt_nxt = r_cnt + 7'd1;
            end
         end

         StSend: begin
            // r_cnt counts bits already placed on the line.
            if (r_cnt == FrameBits) begin
               w_oe_nxt    = 1'b0;
               w_out_nxt   = 1'b1;
               w_state_nxt = StIdle;
            end else begin
               w_out_nxt  = r_resp[47];
               w_resp_nxt = {r_resp[46:0], 1'b1};
               w_cnt_nxt  = r_cnt + 7'd1;
            end
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk_SD or posedge reset_SD) begin
      if (reset_SD) begin
         r_state <= StIdle;
         r_cnt   <= 7'd0;
         r_shift <= 48'd0;
         r_crc   <= 7'd0;
         r_resp  <= 48'hFFFF_FFFF_FFFF;
         r_out   <= 1'b1;
         r_oe    <= 1'b0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_index <= 6'd0;
         r_arg   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
         r_crc   <= w_crc_nxt;
         r_resp  <= w_resp_nxt;
         r_out   <= w_out_nxt;
         r_oe    <= w_oe_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         r_index <= w_index_nxt;
         r_arg   <= w_arg_nxt;
      end
   end

   assign CMD_PIN_OUT   = r_out;
   assign io_enable_cmd = r_oe;
   assign cmd_index     = r_index;
   assign cmd_argument  = r_arg;
   assign cmd_valid     = r_valid;
   assign crc_error     = r_err;
   assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: one DUT at NCR=2 fully checked, a second at NCR=5
// checked for response start timing. Expected events are queued when frames are driven.
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;

   localparam int unsigned Ncr     = 2;
   localparam int unsigned NcrSlow = 5;

   typedef struct {
      logic        valid;
      logic [5:0]  idx;
      logic [31:0] arg;
      int          cyc;
   } cmd_exp_t;

   typedef struct {
      logic [47:0] bits;
      int          cyc;
   } resp_exp_t;

   cmd_exp_t  cmd_q[$];
   resp_exp_t resp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic        clk_SD      = 1'b0;
   logic        reset_SD    = 1'b1;
   logic        CMD_PIN_IN  = 1'b1;
   logic [31:0] card_status = 32'd0;
   logic [5:0]  resp_index  = 6'd0;
   logic        resp_crc_en = 1'b1;

   logic        CMD_PIN_OUT, io_enable_cmd, cmd_valid, crc_error, busy;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_argument;

   logic        out5, oe5, valid5, err5, busy5;
   logic [5:0]  index5;
   logic [31:0] arg5;

   logic        rst_abort = 1'b0;
   logic [5:0]  last_idx  = 6'd0;
   logic [31:0] last_arg  = 32'd0;

   localparam logic [47:0] FrmCmd0  = 48'h40_0000_0000_95;
   localparam logic [47:0] FrmCmd55 = 48'h77_0000_0000_65;
   localparam logic [47:0] FrmCmd8  = 48'h48_0000_01AA_87;
   localparam logic [47:0] FrmCmd41 = 48'h69_4000_0000_77;

   sd_card_cmd_responder #(.NCR(Ncr), .NO_RESP_INDEX(6'd0)) u_dut (
      .clk_SD        (clk_SD),
      .reset_SD      (reset_SD),
      .CMD_PIN_IN    (CMD_PIN_IN),
      .CMD_PIN_OUT   (CMD_PIN_OUT),
      .io_enable_cmd (io_enable_cmd),
      .cmd_index     (cmd_index),
      .cmd_argument  (cmd_argument),
      .cmd_valid     (cmd_valid),
      .crc_error     (crc_error),
      .card_status   (card_status),
      .resp_index    (resp_index),
      .resp_crc_en   (resp_crc_en),
      .busy          (busy)
   );

   sd_card_cmd_responder #(.NCR(NcrSlow), .NO_RESP_INDEX(6'd0)) u_dut_ncr5 (
      .clk_SD        (clk_SD),
      .reset_SD      (reset_SD),
      .CMD_PIN_IN    (CMD_PIN_IN),
      .CMD_PIN_OUT   (out5),
      .io_enable_cmd (oe5),
      .cmd_index     (index5),
      .cmd_argument  (arg5),
      .cmd_valid     (valid5),
      .crc_error     (err5),
      .card_status   (card_status),
      .resp_index    (resp_index),
      .resp_crc_en   (resp_crc_en),
      .busy          (busy5)
   );

   always #5 clk_SD = ~clk_SD;

   always @(posedge clk_SD) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Reference CRC7 (x^7 + x^3 + 1, init 0) over 40 bits MSB first.
   function automatic logic [6:0] crc7_ref(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'b000_1001;
      end
      return c;
   endfunction

   // Drive one frame MSB first and queue what the card must do with it.
   task automatic send_cmd(input logic [47:0] frame, input logic exp_ok,
                           input logic [31:0] status, input logic [5:0] ridx, input logic rcrc);
      cmd_exp_t    ce;
      resp_exp_t   re;
      logic [39:0] hdr;
      card_status = status;
      resp_index  = ridx;
      resp_crc_en = rcrc;
      for (int i = 47; i >= 0; i--) begin
         @(negedge clk_SD);
         CMD_PIN_IN = frame[i];
      end
      // End bit is sampled on the next rising edge E; cmd_valid is observed after E+1.
      ce.valid = exp_ok;
      ce.idx   = exp_ok ? frame[45:40] : last_idx;
      ce.arg   = exp_ok ? frame[39:8] : last_arg;
      ce.cyc   = cyc + 2;
      cmd_q.push_back(ce);
      if (exp_ok) begin
         last_idx = frame[45:40];
         last_arg = frame[39:8];
         if (frame[45:40] != 6'd0) begin
            hdr     = {2'b00, ridx, status};
            re.bits = {hdr, (rcrc ? crc7_ref(hdr) : 7'h7F), 1'b1};
            re.cyc  = cyc + 2 + Ncr;
            resp_q.push_back(re);
         end
      end
      @(negedge clk_SD);
      CMD_PIN_IN = 1'b1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || busy5) && k < 400) begin
         @(negedge clk_SD);
         k++;
      end
      check("idle_reached", {busy, busy5}, 2'b00);
      repeat (10) @(negedge clk_SD);
   endtask

   // Command event monitor: pops one expectation per cmd_valid/crc_error pulse.
   initial begin : cmd_mon
      cmd_exp_t ce;
      forever begin
         @(negedge clk_SD);
         if (cmd_valid || crc_error) begin
            check("valid_err_exclusive", cmd_valid && crc_error, 1'b0);
            check("cmd_event_expected", cmd_q.size() != 0, 1'b1);
            if (cmd_q.size() != 0) begin
               ce = cmd_q.pop_front();
               check("cmd_valid", cmd_valid, ce.valid);
               check("crc_error", crc_error, !ce.valid);
               check("cmd_cycle", cyc, ce.cyc);
               check("cmd_index", cmd_index, ce.idx);
               check("cmd_argument", cmd_argument, ce.arg);
            end
         end
      end
   end

   // Response monitor: collects bits while the card drives the line.
   initial begin : resp_mon
      logic [47:0] bits;
      int          n;
      int          start;
      resp_exp_t   re;
      bits  = '0;
      n     = 0;
      start = 0;
      forever begin
         @(negedge clk_SD);
         if (io_enable_cmd) begin
            if (n == 0) start = cyc;
            bits = {bits[46:0], CMD_PIN_OUT};
            n++;
            if (n == 49) check("resp_overrun", n, 48);
         end else if (n > 0) begin
            check("line_released", CMD_PIN_OUT, 1'b1);
            if (rst_abort) begin
               check("rst_abort_bit_count", n, 21);
               if (resp_q.size() != 0) void'(resp_q.pop_front());
               rst_abort = 1'b0;
            end else begin
               check("resp_len", n, 48);
               check("resp_expected", resp_q.size() != 0, 1'b1);
               if (resp_q.size() != 0) begin
                  re = resp_q.pop_front();
                  check("resp_bits", bits, re.bits);
                  check("resp_start_cycle", start, re.cyc);
               end
            end
            n = 0;
         end
      end
   end

   // NCR=5 instance: response start bit must come exactly NcrSlow cycles after cmd_valid.
   initial begin : ncr5_mon
      int   vcyc;
      logic oe_prev;
      vcyc    = 0;
      oe_prev = 1'b0;
      forever begin
         @(negedge clk_SD);
         if (valid5) vcyc = cyc;
         if (oe5 && !oe_prev) begin
            check("ncr5_start_gap", cyc - vcyc, NcrSlow);
            check("ncr5_start_bit", out5, 1'b0);
         end
         oe_prev = oe5;
      end
   end

   initial begin : main
      int k;
      repeat (3) @(negedge clk_SD);
      #1;
      check("rst_cmd_out", CMD_PIN_OUT, 1'b1);
      check("rst_oe", io_enable_cmd, 1'b0);
      check("rst_valid", cmd_valid, 1'b0);
      check("rst_crc_error", crc_error, 1'b0);
      check("rst_index", cmd_index, 6'd0);
      check("rst_argument", cmd_argument, 32'd0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk_SD);
      #2 reset_SD = 1'b0;
      repeat (5) @(negedge clk_SD);

      // CMD0: accepted, no response
      send_cmd(FrmCmd0, 1'b1, 32'h0000_0000, 6'd0, 1'b1);
      wait_idle();
      // CMD55 with R1
      send_cmd(FrmCmd55, 1'b1, 32'h0000_0120, 6'd55, 1'b1);
      wait_idle();
      // CMD8 with R7; NCR=5 timing checked on the second instance
      send_cmd(FrmCmd8, 1'b1, 32'h0000_01AA, 6'd8, 1'b1);
      wait_idle();
      // Corrupted CMD55 (argument LSB flipped), then a good one
      send_cmd(FrmCmd55 ^ 48'h0000_0000_0100, 1'b0, 32'h0000_0120, 6'd55, 1'b1);
      wait_idle();
      check("err_hold_index", cmd_index, 6'd8);
      check("err_hold_argument", cmd_argument, 32'h0000_01AA);
      send_cmd(FrmCmd55, 1'b1, 32'h0000_0120, 6'd55, 1'b1);
      wait_idle();
      // CMD41 with R3 (no CRC)
      send_cmd(FrmCmd41, 1'b1, 32'h80FF_8000, 6'h3F, 1'b0);
      wait_idle();

      // Reset during response bit 20
      send_cmd(FrmCmd55, 1'b1, 32'h0000_0900, 6'd55, 1'b1);
      k = 0;
      while (!io_enable_cmd && k < 50) begin
         @(negedge clk_SD);
         k++;
      end
      check("rst_test_resp_started", io_enable_cmd, 1'b1);
      repeat (20) @(negedge clk_SD);
      check("busy_mid_resp", busy, 1'b1);
      #2;
      rst_abort = 1'b1;
      reset_SD  = 1'b1;
      #1;
      check("midrst_cmd_out", CMD_PIN_OUT, 1'b1);
      check("midrst_oe", io_enable_cmd, 1'b0);
      check("midrst_busy", busy, 1'b0);
      repeat (3) @(negedge clk_SD);
      #2 reset_SD = 1'b0;
      last_idx = 6'd0;
      last_arg = 32'd0;
      repeat (5) @(negedge clk_SD);
      send_cmd(FrmCmd55, 1'b1, 32'h0000_0120, 6'd55, 1'b1);
      wait_idle();

      check("cmd_q_drained", cmd_q.size(), 0);
      check("resp_q_drained", resp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
